// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: PC register, single-outstanding fetch handshake, redirect/drop handling.
// Optional misaligned-redirect trap enabled by defining MISALIGN_TRAP_EN.
module fetch_pc_unit #(
  parameter int unsigned        BITSIZE      = 32,
  parameter logic [BITSIZE-1:0] RESET_VECTOR = '0,
  parameter int unsigned        INCR         = 4
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               Stall,
  input  logic               RedirectValid,
  input  logic [BITSIZE-1:0] RedirectAddr,
  output logic               ReqValid,
  output logic [BITSIZE-1:0] ReqAddr,
  input  logic               ReqReady,
  input  logic               RspValid,
  input  logic [BITSIZE-1:0] RspData,
  output logic               InstrValid,
  output logic [BITSIZE-1:0] InstrData,
  output logic [BITSIZE-1:0] InstrPC
`ifdef MISALIGN_TRAP_EN
  ,
  output logic               MisalignFault,
  output logic [BITSIZE-1:0] FaultAddr
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DROP  = 2'd3;

  logic [1:0]         state, state_nxt;
  logic [BITSIZE-1:0] pc, pc_nxt;
  logic [BITSIZE-1:0] req_pc, req_pc_nxt;
  logic               instr_valid_nxt;
  logic [BITSIZE-1:0] instr_data_nxt, instr_pc_nxt;
  logic               redirect_load;

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  // A misaligned target still kills the in-flight fetch but never reaches the PC.
  assign misaligned    = RedirectValid && (RedirectAddr[1:0] != 2'b00);
  assign redirect_load = RedirectValid && !misaligned;
`else
  assign redirect_load = RedirectValid;
`endif

  assign ReqAddr = pc;

  // Next-state and datapath update
  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    req_pc_nxt      = req_pc;
    instr_valid_nxt = 1'b0;
    instr_data_nxt  = InstrData;
    instr_pc_nxt    = InstrPC;
    ReqValid        = 1'b0;

    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        ReqValid = !Stall && !RedirectValid;
        if (ReqValid && ReqReady) begin
          req_pc_nxt = pc;
          pc_nxt     = pc + BITSIZE'(INCR);
          state_nxt  = WAIT;
        end
      end
      WAIT: begin
        if (RedirectValid) begin
          state_nxt = RspValid ? FETCH : DROP;
        end else if (RspValid) begin
          instr_valid_nxt = 1'b1;
          instr_data_nxt  = RspData;
          instr_pc_nxt    = req_pc;
          state_nxt       = FETCH;
        end
      end
      DROP: begin
        // The stale response is swallowed whenever it shows up, redirect or not.
        if (RspValid) state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase

    if (redirect_load) pc_nxt = RedirectAddr;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= IDLE;
      pc         <= RESET_VECTOR;
      req_pc     <= '0;
      InstrValid <= 1'b0;
      InstrData  <= '0;
      InstrPC    <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      req_pc     <= req_pc_nxt;
      InstrValid <= instr_valid_nxt;
      InstrData  <= instr_data_nxt;
      InstrPC    <= instr_pc_nxt;
    end
  end

`ifdef MISALIGN_TRAP_EN
  // Fault pulse with the offending target captured alongside it
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      MisalignFault <= 1'b0;
      FaultAddr     <= '0;
    end else begin
      MisalignFault <= misaligned;
      if (misaligned) FaultAddr <= RedirectAddr;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed self-checking bench for fetch_pc_unit with a simple latency-configurable memory responder.
module tb_fetch_pc_unit;

  localparam int unsigned W = 32;
  localparam logic [W-1:0] K = 32'hA5A5A5A5;

  logic         Clk;
  logic         Rst_n;
  logic         Stall;
  logic         RedirectValid;
  logic [W-1:0] RedirectAddr;
  logic         ReqValid;
  logic [W-1:0] ReqAddr;
  logic         ReqReady;
  logic         RspValid;
  logic [W-1:0] RspData;
  logic         InstrValid;
  logic [W-1:0] InstrData;
  logic [W-1:0] InstrPC;
`ifdef MISALIGN_TRAP_EN
  logic         MisalignFault;
  logic [W-1:0] FaultAddr;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Memory responder state
  bit           pend;
  int           cnt;
  int           rsp_lat;
  logic [W-1:0] pend_addr;

  fetch_pc_unit dut (
    .Clk           (Clk),
    .Rst_n         (Rst_n),
    .Stall         (Stall),
    .RedirectValid (RedirectValid),
    .RedirectAddr  (RedirectAddr),
    .ReqValid      (ReqValid),
    .ReqAddr       (ReqAddr),
    .ReqReady      (ReqReady),
    .RspValid      (RspValid),
    .RspData       (RspData),
    .InstrValid    (InstrValid),
    .InstrData     (InstrData),
    .InstrPC       (InstrPC)
`ifdef MISALIGN_TRAP_EN
    ,
    .MisalignFault (MisalignFault),
    .FaultAddr     (FaultAddr)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: memory sees the handshake, answers rsp_lat cycles after acceptance
  task automatic tick();
    logic         acc;
    logic [W-1:0] a;
    acc = ReqValid && ReqReady;
    a   = ReqAddr;
    @(posedge Clk);
    #1;
    RspValid = 1'b0;
    if (acc) begin
      pend      = 1'b1;
      pend_addr = a;
      cnt       = rsp_lat;
    end
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        RspValid = 1'b1;
        RspData  = pend_addr ^ K;
        pend     = 1'b0;
      end
    end
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Rst_n = 1'b1; Stall = 1'b0; RedirectValid = 1'b0; RedirectAddr = '0;
    ReqReady = 1'b1; RspValid = 1'b0; RspData = '0;
    pend = 1'b0; cnt = 0; rsp_lat = 1; pend_addr = '0;
    #1 Rst_n = 1'b0;
    #1;
    check("rst_instr_valid", W'(InstrValid), 32'd0);
    check("rst_instr_data", InstrData, 32'd0);
    check("rst_instr_pc", InstrPC, 32'd0);
    check("rst_req_valid", W'(ReqValid), 32'd0);
    check("rst_req_addr", ReqAddr, 32'd0);
    repeat (2) @(posedge Clk);
    #1 Rst_n = 1'b1;
    tick();

    // Sequential fetch, 1-cycle memory latency
    for (int k = 0; k < 4; k++) begin
      check("seq_req_valid", W'(ReqValid), 32'd1);
      check("seq_req_addr", ReqAddr, W'(k * 4));
      tick();
      check("seq_wait_req_valid", W'(ReqValid), 32'd0);
      check("seq_gap_instr_valid", W'(InstrValid), 32'd0);
      tick();
      check("seq_instr_valid", W'(InstrValid), 32'd1);
      check("seq_instr_pc", InstrPC, W'(k * 4));
      check("seq_instr_data", InstrData, W'(k * 4) ^ K);
    end

    // Stall three cycles in FETCH
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_req_valid", W'(ReqValid), 32'd0);
      check("stall_req_addr", ReqAddr, 32'd16);
      tick();
    end
    Stall = 1'b0;
    #1;
    check("unstall_req_valid", W'(ReqValid), 32'd1);
    check("unstall_req_addr", ReqAddr, 32'd16);
    check("unstall_instr_valid", W'(InstrValid), 32'd0);

    // Redirect in WAIT, response two cycles later is dropped
    rsp_lat = 3;
    tick();
    RedirectValid = 1'b1; RedirectAddr = 32'h100;
    #1;
    check("wait_redir_req_valid", W'(ReqValid), 32'd0);
    tick();
    RedirectValid = 1'b0;
    #1;
    check("drop_req_valid", W'(ReqValid), 32'd0);
    check("drop_pc", ReqAddr, 32'h100);
    tick();
    check("drop_instr_valid0", W'(InstrValid), 32'd0);
    tick();
    check("drop_instr_valid1", W'(InstrValid), 32'd0);
    check("after_drop_req_valid", W'(ReqValid), 32'd1);
    check("after_drop_req_addr", ReqAddr, 32'h100);
    rsp_lat = 1;
    tick();
    tick();
    check("redir_instr_valid", W'(InstrValid), 32'd1);
    check("redir_instr_pc", InstrPC, 32'h100);
    check("redir_instr_data", InstrData, 32'hA5A5A4A5);

    // Redirect coincident with the response
    tick();
    RedirectValid = 1'b1; RedirectAddr = 32'h200;
    #1;
    tick();
    RedirectValid = 1'b0;
    #1;
    check("coinc_instr_valid", W'(InstrValid), 32'd0);
    check("coinc_instr_pc_hold", InstrPC, 32'h100);
    check("coinc_req_valid", W'(ReqValid), 32'd1);
    check("coinc_req_addr", ReqAddr, 32'h200);

    // Redirect in FETCH to the top of the address space, then wrap
    RedirectValid = 1'b1; RedirectAddr = 32'hFFFF_FFFC;
    #1;
    check("fetch_redir_req_valid", W'(ReqValid), 32'd0);
    tick();
    RedirectValid = 1'b0;
    #1;
    check("top_req_addr", ReqAddr, 32'hFFFF_FFFC);
    tick();
    tick();
    check("top_instr_pc", InstrPC, 32'hFFFF_FFFC);
    check("top_instr_data", InstrData, 32'h5A5A_5A59);
    check("wrap_req_addr", ReqAddr, 32'h0);

    // Back-to-back redirects: last wins
    RedirectValid = 1'b1; RedirectAddr = 32'h300;
    tick();
    RedirectAddr = 32'h400;
    tick();
    RedirectValid = 1'b0;
    #1;
    check("b2b_req_valid", W'(ReqValid), 32'd1);
    check("b2b_req_addr", ReqAddr, 32'h400);

    // Reset while a request is outstanding
    tick();
    Rst_n = 1'b0;
    #1;
    check("midrst_instr_data", InstrData, 32'd0);
    check("midrst_instr_pc", InstrPC, 32'd0);
    check("midrst_instr_valid", W'(InstrValid), 32'd0);
    check("midrst_req_valid", W'(ReqValid), 32'd0);
    check("midrst_req_addr", ReqAddr, 32'd0);
    pend = 1'b0; RspValid = 1'b0;
    tick();
    tick();
    Rst_n = 1'b1;
    tick();
    check("post_rst_req_valid", W'(ReqValid), 32'd1);
    check("post_rst_req_addr", ReqAddr, 32'd0);
    tick();
    tick();
    check("post_rst_instr_pc", InstrPC, 32'd0);
    check("post_rst_req_addr4", ReqAddr, 32'd4);

    // Misaligned redirect target
`ifdef MISALIGN_TRAP_EN
    check("mis_fault_idle", W'(MisalignFault), 32'd0);
    RedirectValid = 1'b1; RedirectAddr = 32'h102;
    #1;
    tick();
    RedirectValid = 1'b0;
    #1;
    check("mis_fault_pulse", W'(MisalignFault), 32'd1);
    check("mis_fault_addr", FaultAddr, 32'h102);
    check("mis_req_addr", ReqAddr, 32'd4);
    check("mis_req_valid", W'(ReqValid), 32'd1);
    tick();
    check("mis_fault_clear", W'(MisalignFault), 32'd0);
    check("mis_fault_addr_hold", FaultAddr, 32'h102);
    tick();
    check("mis_seq_instr_pc", InstrPC, 32'd4);
`else
    RedirectValid = 1'b1; RedirectAddr = 32'h102;
    #1;
    tick();
    RedirectValid = 1'b0;
    #1;
    check("unaligned_req_addr", ReqAddr, 32'h102);
    check("unaligned_req_valid", W'(ReqValid), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch front end. Holds the program counter and issues one outstanding fetch request at a time to instruction memory over a valid/ready handshake.
- Returns each fetched instruction tagged with its PC.
- Consumes the branch/jump target computed by the branch adder as a redirect, and discards any in-flight fetch made stale by that redirect.

Parameters:
- BITSIZE, 32, width of PC, addresses and instruction data.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- INCR, 4, sequential PC increment in bytes.

Ports:
- Clk  input  1  rising-edge clock
- Rst_n  input  1  asynchronous active-low reset
- Stall  input  1  holds off issue of new fetch requests
- RedirectValid  input  1  redirect request, single-cycle qualifier
- RedirectAddr  input  BITSIZE  branch/jump target PC
- ReqValid  output  1  fetch request valid
- ReqAddr  output  BITSIZE  fetch address (equals current PC)
- ReqReady  input  1  memory accepts request
- RspValid  input  1  memory response valid; always accepted
- RspData  input  BITSIZE  fetched instruction word
- InstrValid  output  1  registered one-cycle pulse: instruction delivered
- InstrData  output  BITSIZE  delivered instruction
- InstrPC  output  BITSIZE  PC of delivered instruction

Behaviour:
- Reset (Rst_n low, asynchronous):
  - state=IDLE, PC=RESET_VECTOR, ReqPC=0.
  - InstrValid=0, InstrData=0, InstrPC=0.
  - ReqValid=0.
- States: IDLE, FETCH, WAIT, DROP.
- IDLE: unconditionally to FETCH next cycle. A redirect seen in IDLE loads PC.
- FETCH:
  - ReqValid = !Stall && !RedirectValid (combinational); ReqAddr = PC.
  - Handshake = ReqValid && ReqReady: ReqPC<=PC, PC<=PC+INCR, go to WAIT.
  - PC arithmetic is modulo 2^BITSIZE: 0xFFFF_FFFC + 4 wraps to 0.
- WAIT:
  - ReqValid=0; Stall is ignored.
  - On RspValid: next edge InstrValid=1, InstrData<=RspData, InstrPC<=ReqPC, go to FETCH.
  - Memory response never arrives in the same cycle as acceptance; the earliest is the following cycle.
- DROP:
  - ReqValid=0.
  - On RspValid: response discarded (InstrValid stays 0), go to FETCH.
- Redirect (RedirectValid high) has the highest priority in every state; PC<=RedirectAddr.
  - FETCH: the request is suppressed that cycle; state stays FETCH.
  - WAIT with RspValid in the same cycle: response discarded, go to FETCH.
  - WAIT without RspValid: go to DROP.
  - DROP: PC is updated, state stays DROP.
- Back-to-back redirects: the last one wins.
- InstrValid is high for exactly one cycle per delivered instruction. InstrData and InstrPC hold their values until the next delivery.
- Throughput: at most one instruction every 2 cycles (accept cycle + response cycle minimum). Only one request is outstanding at any time.
- Reset mid-operation: any outstanding request is forgotten. The memory side must also be reset; a post-reset stale response is not guarded.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Adds output MisalignFault (1) and FaultAddr (BITSIZE).
  - A redirect with RedirectAddr[1:0]!=0 is not taken: PC and state are unchanged, except a WAIT to DROP transition still occurs.
  - MisalignFault pulses for one cycle, registered, and FaultAddr<=RedirectAddr.
  - Reset value of both outputs is 0.
- Undefined: ports absent; RedirectAddr is loaded verbatim regardless of alignment.

Test Plan:
- Reset release, ReqReady=1, memory responds 1 cycle after accept with data=addr^0xA5A5A5A5 -> ReqAddr sequence 0,4,8,12; InstrPC 0,4,8,12 with matching InstrData; InstrValid period 2 cycles.
- Stall high for 3 cycles in FETCH -> ReqValid=0 for those cycles, PC unchanged, fetch resumes at the same address.
- Redirect to 0x100 in WAIT, response arrives 2 cycles later -> that response dropped (no InstrValid), next ReqAddr=0x100, next InstrPC=0x100.
- Redirect to 0x200 in the same cycle as RspValid -> no InstrValid; next ReqAddr=0x200.
- PC=0xFFFFFFFC fetched -> next ReqAddr=0x0; Rst_n asserted mid-WAIT -> outputs return to 0 immediately, first ReqAddr after release = RESET_VECTOR.
- MISALIGN_TRAP_EN: redirect to 0x102 -> MisalignFault pulse, FaultAddr=0x102, fetch continues sequentially from the unchanged PC.
